attn_score_buffer: RTL
======================

ATTN_SCORE_BUFFER -- requirements
Module: attn_score_buffer

Interface
REQ-001 Parameter DATA_W, default 20, width of one attention-score word (5 bits x 4 time steps).
REQ-002 Parameter DEPTH, default 4096, words per frame (64 x 64 token pairs).
REQ-003 Parameter ADDR_W, default 12, address width; SHALL equal clog2(DEPTH).
REQ-004 s_clk  in  1  clock; all logic rising-edge.
REQ-005 s_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_attn_valid  in  1  write word valid from Q@K^T score producer.
REQ-007 i_attn_data  in  DATA_W  score word, raster order, row-major.
REQ-008 o_attn_ready  out  1  buffer can accept a write this cycle.
REQ-009 i_AttnRam_rd_addr  in  ADDR_W  read address from downstream Attn@V consumer.
REQ-010 o_AttnRAM_data  out  DATA_W  read data, 1 clk after address.
REQ-011 o_AttnRAM_Empty  out  1  high when no complete frame is available to the consumer.
REQ-012 i_AttnRam_Done  in  1  consumer finished current frame; acts on rising edge only.
REQ-013 o_done_err  out  1  1-clk pulse: Done edge received while Empty.

Function
REQ-014 Storage SHALL be two banks of DEPTH x DATA_W (simple dual-port RAM inference), one flag full[b] per bank.
REQ-015 Write accepted when i_attn_valid && o_attn_ready; word written to bank wr_bank at wr_addr.
REQ-016 wr_addr SHALL increment per accepted word and wrap DEPTH-1 -> 0; on the write at DEPTH-1, full[wr_bank] <= 1 and wr_bank toggles, same edge.
REQ-017 o_attn_ready = !full[wr_bank] (combinational); valid while not ready SHALL be ignored, no data lost by producer contract.
REQ-018 o_AttnRAM_Empty = !full[rd_bank] (combinational from registers).
REQ-019 o_AttnRAM_data SHALL be registered mem[rd_bank][i_AttnRam_rd_addr], latency exactly 1 clk, read every cycle regardless of Empty.
REQ-020 Rising edge of i_AttnRam_Done with full[rd_bank]=1: full[rd_bank] <= 0, rd_bank toggles on the same edge.
REQ-021 Read issued in the Done-edge cycle SHALL use the pre-toggle rd_bank (consumer reads last address 4095 while Done is high).
REQ-022 Done held high multiple cycles SHALL release only one frame; a new release needs Done low for >=1 clk.
REQ-023 Done edge while Empty: no state change, o_done_err pulses 1 clk.
REQ-024 Frame completion on wr_bank and Done release on rd_bank in the same cycle SHALL both take effect.
REQ-025 Released bank becomes writable the next cycle (o_attn_ready rises 1 clk after Done edge when both banks were full).
REQ-026 Frames SHALL be delivered in write order; no reordering or overwrite of a full bank.

Reset
REQ-027 On s_rst: wr_addr=0, wr_bank=0, rd_bank=0, full[1:0]=0, Done edge detector=0, o_done_err=0, o_AttnRAM_data=0.
REQ-028 Reset outputs after reset: o_attn_ready=1, o_AttnRAM_Empty=1.
REQ-029 RAM contents SHALL NOT be reset; reset mid-frame discards partial and complete frames.

Configuration
REQ-030 Macro ATTN_BUF_PINGPONG_EN: when defined, two banks per REQ-014..026.
REQ-031 When undefined: one bank only, wr_bank/rd_bank fixed 0; o_attn_ready=0 from frame completion until Done release; REQ-024 does not arise.

Verification
REQ-032 Reset, write 4096 words data=addr -> Empty falls 1 clk after word 4095 accepted; reads addr 0/4095 return 0/4095 next clk.
REQ-033 Pingpong: write frame A (addr), frame B (addr^0xFFFFF) -> ready=0 after B; Done edge -> ready=1 next clk, reads return B pattern.
REQ-034 Done asserted while consumer reads addr 4095 -> data returned is frame A word 4095, not frame B.
REQ-035 Done held 5 clks with two full frames -> only one frame released, Empty stays 0, B readable.
REQ-036 Done edge with Empty=1 -> o_done_err single pulse, full flags unchanged.
REQ-037 s_rst asserted after 2000 writes -> ready=1, Empty=1; next frame fills from addr 0 correctly; repeat REQ-032 with macro undefined, ready=0 until Done.

Source files
------------

// File: rtl/attn_score_buffer.sv
// attn_score_buffer: frame buffer between the Q@K^T score producer and the Attn@V consumer.
// Ports:
//   s_clk, s_rst               clock, asynchronous active-high reset
//   i_attn_valid, i_attn_data  raster-order score words from the producer
//   o_attn_ready               a write is accepted this cycle
//   i_AttnRam_rd_addr          consumer read address
//   o_AttnRAM_data             registered read data, 1 clk after the address
//   o_AttnRAM_Empty            no complete frame available to the consumer
//   i_AttnRam_Done             consumer finished its frame (rising edge acts)
//   o_done_err                 1-clk pulse: Done edge arrived while Empty
// Macro ATTN_BUF_PINGPONG_EN: two banks (ping-pong); undefined gives a single bank.
module attn_score_buffer #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              i_attn_valid,
  input  logic [DATA_W-1:0] i_attn_data,
  output logic              o_attn_ready,
  input  logic [ADDR_W-1:0] i_AttnRam_rd_addr,
  output logic [DATA_W-1:0] o_AttnRAM_data,
  output logic              o_AttnRAM_Empty,
  input  logic              i_AttnRam_Done,
  output logic              o_done_err
);
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              done_err_q, done_err_d;
  logic              wr_full, rd_full, wr_en, frame_end, done_rise, release_frame;
`ifdef ATTN_BUF_PINGPONG_EN
  logic [DATA_W-1:0] mem [2][DEPTH];
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  assign wr_full = full_q[wr_bank_q];
  assign rd_full = full_q[rd_bank_q];
`else
  logic [DATA_W-1:0] mem [DEPTH];
  logic              full_q, full_d;
  assign wr_full = full_q;
  assign rd_full = full_q;
`endif
  assign o_attn_ready    = !wr_full;
  assign o_AttnRAM_Empty = !rd_full;
  assign o_AttnRAM_data  = rd_data_q;
  assign o_done_err      = done_err_q;
  assign wr_en           = i_attn_valid && !wr_full;
  assign frame_end       = wr_en && (wr_addr_q == ADDR_W'(DEPTH - 1));
  assign done_rise       = i_AttnRam_Done && !done_q;
  assign release_frame   = done_rise && rd_full;
  always_comb begin
    wr_addr_d  = wr_en ? (frame_end ? '0 : wr_addr_q + 1'b1) : wr_addr_q;
    done_d     = i_AttnRam_Done;
    done_err_d = done_rise && !rd_full;
`ifdef ATTN_BUF_PINGPONG_EN
    // Banks differ whenever both events fire, so completion and release never collide.
    full_d = full_q;
    if (frame_end) full_d[wr_bank_q] = 1'b1;
    if (release_frame) full_d[rd_bank_q] = 1'b0;
    wr_bank_d = frame_end ? !wr_bank_q : wr_bank_q;
    rd_bank_d = release_frame ? !rd_bank_q : rd_bank_q;
    // Uses the pre-toggle bank, so the read issued with the Done edge still sees the old frame.
    rd_data_d = mem[rd_bank_q][i_AttnRam_rd_addr];
`else
    full_d    = frame_end ? 1'b1 : (release_frame ? 1'b0 : full_q);
    rd_data_d = mem[i_AttnRam_rd_addr];
`endif
  end
  always_ff @(posedge s_clk) begin
`ifdef ATTN_BUF_PINGPONG_EN
    if (wr_en) mem[wr_bank_q][wr_addr_q] <= i_attn_data;
`else
    if (wr_en) mem[wr_addr_q] <= i_attn_data;
`endif
  end
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      wr_addr_q  <= '0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      full_q     <= '0;
`ifdef ATTN_BUF_PINGPONG_EN
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
`endif
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
      full_q     <= full_d;
`ifdef ATTN_BUF_PINGPONG_EN
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
`endif
    end
  end
endmodule
